cv32e40p_apu_disp_q: RTL and testbench
======================================

Name: cv32e40p_apu_disp_q

Overview:
Parametrised APU dispatcher. Tracks up to DEPTH outstanding multicycle APU operations in an in-order return queue, replacing the fixed two-slot inflight/waiting pair. Sits between the ID-stage APU request path and the APU interconnect handshake. Provides register-dependency checks over all outstanding entries, latency-ordering stalls, occupancy reporting and spurious-response detection.

Parameters:
DEPTH, 2, max outstanding multicycle ops (>=1)
ADDR_W, 6, width of destination register address
NRD, 3, number of read-register dependency ports
NWR, 2, number of write-register dependency ports
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived; do not override)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
setback_i  in  1  synchronous flush of all state
enable_i  in  1  ID requests an APU op this cycle
apu_lat_i  in  2  latency class of request (0..3; 3 = multicycle)
apu_waddr_i  in  ADDR_W  destination of request
apu_waddr_o  out  ADDR_W  destination of returning op
apu_multicycle_o  out  1  last issued latency class == 3
apu_singlecycle_o  out  1  queue empty
active_o  out  1  queue non-empty
count_o  out  CNT_W  outstanding entries
stall_o  out  1  ID must stall
is_decoding_i  in  1  ID decoding valid instruction
read_regs_i  in  NRD*ADDR_W  read register addresses
read_regs_valid_i  in  NRD  read port valid
read_dep_o  out  1  RAW hazard
write_regs_i  in  NWR*ADDR_W  write register addresses
write_regs_valid_i  in  NWR  write port valid
write_dep_o  out  1  WAW hazard
perf_type_o  out  1  type stall (=stall_type)
perf_cont_o  out  1  contention stall (=stall_nack)
spurious_o  out  1  one-cycle pulse, rvalid with nothing to return
apu_req_o  out  1  request to interconnect
apu_gnt_i  in  1  grant
apu_rvalid_i  in  1  response valid

Behaviour:
- Reset (async) and setback_i (sync, highest priority): queue empty, count 0, last_lat 0, head/tail ptrs 0, all entry addrs 0. Outputs then: active_o 0, singlecycle_o 1, multicycle_o 0, count_o 0, spurious_o 0.
- Queue: circular buffer of DEPTH addrs, head = oldest. Ptrs wrap at DEPTH (non power-of-2 supported).
- stall_full = (count == DEPTH); no same-cycle pop bypass.
- stall_type = enable_i & active & (lat_i==1 | (lat_i==2 & last_lat==3) | lat_i==3).
- valid_req = enable_i & !stall_full & !stall_type; apu_req_o = valid_req; stall_nack = valid_req & !apu_gnt_i.
- stall_o = stall_full | stall_type | stall_nack.
- last_lat <= apu_lat_i whenever valid_req.
- Return: apu_rvalid_i with count>0 pops head, apu_waddr_o = head addr. With count==0 and valid_req: single-cycle return, apu_waddr_o = apu_waddr_i, no push. Otherwise apu_waddr_o = 0.
- Push: valid_req & apu_gnt_i & !returned_req writes apu_waddr_i at tail. Push and pop in the same cycle: count unchanged, both ptrs advance.
- spurious_o = apu_rvalid_i & count==0 & !valid_req; combinational pulse, state unchanged.
- Dependencies: an entry matches a port if addr equal and port valid. Entries being popped this cycle and a returned_req are excluded. Request counts if valid_req & !returned_req. read_dep_o / write_dep_o = any match & is_decoding_i.
- multicycle_o = (last_lat==3); singlecycle_o = (count==0); active_o = (count!=0).

Decomposition:
- Package cv32e40p_apu_disp_pkg: latency-class localparams (LAT_1C=1, LAT_2C=2, LAT_MC=3).
- Sub-module cv32e40p_apu_disp_fifo: DEPTH x ADDR_W in-order buffer. Provides push, pop, flush, count, full, empty, head data and a flattened entry-valid/entry-addr vector for dependency compare.
- Dispatcher top holds stall logic, last_lat register and dependency reduction.

Test Plan:
- DEPTH=4: four granted lat=2 reqs (addrs 5,6,7,8), no rvalid -> count_o 4, fifth enable_i gives stall_o=1, apu_req_o=0. Four rvalids -> waddr_o 5,6,7,8 in order, count_o 0.
- Empty queue, enable_i, lat=1, waddr=9, gnt=1, rvalid=1 same cycle -> waddr_o=9, count_o stays 0, no push.
- Queue holds addr 12; read_regs_i[1]=12 valid, is_decoding_i=1 -> read_dep_o=1. Same cycle rvalid pops it -> read_dep_o=0.
- last_lat=3 outstanding; enable_i with lat=2 -> stall_o=1, perf_type_o=1. With lat=0 -> no type stall.
- Full DEPTH=3 queue, setback_i=1 -> next cycle count_o 0, active_o 0, no deps reported. Async reset asserted mid-operation -> immediate clear.
- rvalid with count 0 and no request -> spurious_o=1 for one cycle, count_o stays 0.

Source files
------------

// File: rtl/cv32e40p_apu_disp_pkg.sv
// Shared definitions for the APU dispatcher: latency-class encodings carried on apu_lat_i.
package cv32e40p_apu_disp_pkg;

  localparam logic [1:0] LAT_1C = 2'd1;  // single-cycle unit
  localparam logic [1:0] LAT_2C = 2'd2;  // two-cycle unit
  localparam logic [1:0] LAT_MC = 2'd3;  // multicycle unit

endpackage

// File: rtl/cv32e40p_apu_disp_fifo.sv
// In-order return buffer of destination addresses for outstanding APU operations.
// Ports: clk_i/rst_ni clock and async active-low reset; flush_i synchronous clear;
//        push_i/push_addr_i append at tail; pop_i retire head; count_o/full_o/empty_o
//        occupancy; head_addr_o oldest address; entry_live_o/entry_addr_o per-slot
//        view for dependency compare (the slot popped this cycle is reported not live).
module cv32e40p_apu_disp_fifo
  import cv32e40p_apu_disp_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [ADDR_W-1:0]        push_addr_i,
  output logic [CNT_W-1:0]         count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [ADDR_W-1:0]        head_addr_o,
  output logic [DEPTH-1:0]         entry_live_o,
  output logic [DEPTH*ADDR_W-1:0]  entry_addr_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q;

  // Pointer increment with wrap at DEPTH, so non power-of-2 depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage, pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_i) begin
        mem_q[tail_q] <= push_addr_i;
        tail_q        <= next_ptr(tail_q);
      end
      if (pop_i) head_q <= next_ptr(head_q);
      if (push_i && !pop_i) count_q <= count_q + CNT_W'(1);
      else if (pop_i && !push_i) count_q <= count_q - CNT_W'(1);
    end
  end

  assign count_o     = count_q;
  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign head_addr_o = mem_q[head_q];

  // A slot is live when its distance from head is below the count; the head is
  // dropped while it is being popped so it no longer produces hazards.
  always_comb begin
    int unsigned hd;
    int unsigned cnt;
    int unsigned off;
    entry_live_o = '0;
    entry_addr_o = '0;
    hd  = 32'(head_q);
    cnt = 32'(count_q);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off = (i >= hd) ? (i - hd) : (i + DEPTH - hd);
      entry_live_o[i] = (off < cnt) && !(pop_i && (off == 0));
      entry_addr_o[i*ADDR_W +: ADDR_W] = mem_q[i];
    end
  end

endmodule

// File: rtl/cv32e40p_apu_disp_q.sv
// APU dispatcher with a DEPTH-entry in-order return queue.
// Ports: clk_i/rst_ni/setback_i clocking, async reset, sync flush; enable_i/apu_lat_i/
//        apu_waddr_i ID request; apu_req_o/apu_gnt_i/apu_rvalid_i interconnect handshake;
//        apu_waddr_o returning destination; stall_o/perf_* stall reporting; read/write
//        register ports and read_dep_o/write_dep_o hazards; count_o/active_o/
//        apu_singlecycle_o/apu_multicycle_o status; spurious_o unexpected response pulse.
module cv32e40p_apu_disp_q
  import cv32e40p_apu_disp_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned NRD    = 3,
  parameter int unsigned NWR    = 2,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  setback_i,
  input  logic                  enable_i,
  input  logic [1:0]            apu_lat_i,
  input  logic [ADDR_W-1:0]     apu_waddr_i,
  output logic [ADDR_W-1:0]     apu_waddr_o,
  output logic                  apu_multicycle_o,
  output logic                  apu_singlecycle_o,
  output logic                  active_o,
  output logic [CNT_W-1:0]      count_o,
  output logic                  stall_o,
  input  logic                  is_decoding_i,
  input  logic [NRD*ADDR_W-1:0] read_regs_i,
  input  logic [NRD-1:0]        read_regs_valid_i,
  output logic                  read_dep_o,
  input  logic [NWR*ADDR_W-1:0] write_regs_i,
  input  logic [NWR-1:0]        write_regs_valid_i,
  output logic                  write_dep_o,
  output logic                  perf_type_o,
  output logic                  perf_cont_o,
  output logic                  spurious_o,
  output logic                  apu_req_o,
  input  logic                  apu_gnt_i,
  input  logic                  apu_rvalid_i
);

  logic [CNT_W-1:0]        count;
  logic                    full, empty;
  logic [ADDR_W-1:0]       head_addr;
  logic [DEPTH-1:0]        entry_live;
  logic [DEPTH*ADDR_W-1:0] entry_addr;
  logic [1:0]              last_lat_q;

  logic stall_type, stall_nack, valid_req, returned_req, push, pop, req_live;
  logic read_match, write_match;

  // Request qualification: a younger op may not overtake an older, slower one.
  assign stall_type   = enable_i & !empty &
                        ((apu_lat_i == LAT_1C) |
                         ((apu_lat_i == LAT_2C) & (last_lat_q == LAT_MC)) |
                         (apu_lat_i == LAT_MC));
  assign valid_req    = enable_i & !full & !stall_type;
  assign stall_nack   = valid_req & !apu_gnt_i;
  // Response for a request issued into an empty queue returns in the same cycle.
  assign returned_req = valid_req & apu_rvalid_i & empty;
  assign pop          = apu_rvalid_i & !empty;
  assign push         = valid_req & apu_gnt_i & !returned_req;
  assign req_live     = valid_req & !returned_req;

  cv32e40p_apu_disp_fifo #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (setback_i),
    .push_i      (push),
    .pop_i       (pop),
    .push_addr_i (apu_waddr_i),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty),
    .head_addr_o (head_addr),
    .entry_live_o(entry_live),
    .entry_addr_o(entry_addr)
  );

  // Latency class of the most recently accepted request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        last_lat_q <= '0;
    else if (setback_i) last_lat_q <= '0;
    else if (valid_req) last_lat_q <= apu_lat_i;
  end

  // Hazard search over surviving queue entries plus the request entering this cycle.
  always_comb begin
    read_match  = 1'b0;
    write_match = 1'b0;
    for (int unsigned p = 0; p < NRD; p++) begin
      if (read_regs_valid_i[p]) begin
        for (int unsigned e = 0; e < DEPTH; e++)
          if (entry_live[e] && (read_regs_i[p*ADDR_W +: ADDR_W] == entry_addr[e*ADDR_W +: ADDR_W]))
            read_match = 1'b1;
        if (req_live && (read_regs_i[p*ADDR_W +: ADDR_W] == apu_waddr_i)) read_match = 1'b1;
      end
    end
    for (int unsigned p = 0; p < NWR; p++) begin
      if (write_regs_valid_i[p]) begin
        for (int unsigned e = 0; e < DEPTH; e++)
          if (entry_live[e] && (write_regs_i[p*ADDR_W +: ADDR_W] == entry_addr[e*ADDR_W +: ADDR_W]))
            write_match = 1'b1;
        if (req_live && (write_regs_i[p*ADDR_W +: ADDR_W] == apu_waddr_i)) write_match = 1'b1;
      end
    end
  end

  assign apu_waddr_o       = pop ? head_addr : (returned_req ? apu_waddr_i : '0);
  assign apu_req_o         = valid_req;
  assign stall_o           = full | stall_type | stall_nack;
  assign perf_type_o       = stall_type;
  assign perf_cont_o       = stall_nack;
  assign spurious_o        = apu_rvalid_i & empty & !valid_req;
  assign read_dep_o        = read_match & is_decoding_i;
  assign write_dep_o       = write_match & is_decoding_i;
  assign apu_multicycle_o  = (last_lat_q == LAT_MC);
  assign apu_singlecycle_o = empty;
  assign active_o          = !empty;
  assign count_o           = count;

endmodule

// File: tb/tb_cv32e40p_apu_disp_q.sv
// Scoreboard bench for cv32e40p_apu_disp_q: a queue-based reference model predicts
// every output for each driven cycle; a monitor compares on the falling edge.
module tb_cv32e40p_apu_disp_q;

  localparam int unsigned DEPTH  = 3;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned NRD    = 3;
  localparam int unsigned NWR    = 2;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  setback, enable, is_decoding, gnt, rvalid;
  logic [1:0]            lat;
  logic [ADDR_W-1:0]     waddr_in, waddr_out;
  logic                  multicycle, singlecycle, active, stall, read_dep, write_dep;
  logic                  perf_type, perf_cont, spurious, req;
  logic [CNT_W-1:0]      count;
  logic [NRD*ADDR_W-1:0] rregs;
  logic [NRD-1:0]        rregs_v;
  logic [NWR*ADDR_W-1:0] wregs;
  logic [NWR-1:0]        wregs_v;

  always #5 clk = ~clk;

  cv32e40p_apu_disp_q #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .NRD(NRD), .NWR(NWR)) dut (
    .clk_i(clk), .rst_ni(rst_n), .setback_i(setback), .enable_i(enable),
    .apu_lat_i(lat), .apu_waddr_i(waddr_in), .apu_waddr_o(waddr_out),
    .apu_multicycle_o(multicycle), .apu_singlecycle_o(singlecycle), .active_o(active),
    .count_o(count), .stall_o(stall), .is_decoding_i(is_decoding),
    .read_regs_i(rregs), .read_regs_valid_i(rregs_v), .read_dep_o(read_dep),
    .write_regs_i(wregs), .write_regs_valid_i(wregs_v), .write_dep_o(write_dep),
    .perf_type_o(perf_type), .perf_cont_o(perf_cont), .spurious_o(spurious),
    .apu_req_o(req), .apu_gnt_i(gnt), .apu_rvalid_i(rvalid)
  );

  typedef struct {
    logic en; logic [1:0] lat; logic [ADDR_W-1:0] waddr; logic gnt, rv, sb, dec;
    logic [NRD*ADDR_W-1:0] rr; logic [NRD-1:0] rrv;
    logic [NWR*ADDR_W-1:0] wr; logic [NWR-1:0] wrv;
  } stim_t;

  typedef struct {
    int waddr, mc, sc, act, cnt, stall, rdep, wdep, ptype, pcont, spur, req;
  } exp_t;

  exp_t exp_q[$];
  int   mq[$];        // model: outstanding destination addresses, oldest first
  int   last_lat = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, expv, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.en = 0; s.lat = 0; s.waddr = 0; s.gnt = 0; s.rv = 0; s.sb = 0; s.dec = 0;
    s.rr = '0; s.rrv = '0; s.wr = '0; s.wrv = '0;
    return s;
  endfunction

  function automatic stim_t req_s(input int l, input int a, input bit g);
    stim_t s = idle();
    s.en = 1; s.lat = 2'(l); s.waddr = ADDR_W'(a); s.gnt = g;
    return s;
  endfunction

  function automatic stim_t ret_s();
    stim_t s = idle();
    s.rv = 1;
    return s;
  endfunction

  // Predict outputs from the current model state, then advance the model.
  task automatic model_step(input stim_t s, output exp_t e);
    int n, live[$];
    bit full, stype, vreq, ret, pop;
    n     = mq.size();
    full  = (n == DEPTH);
    stype = s.en && (n > 0) && (s.lat == 1 || (s.lat == 2 && last_lat == 3) || s.lat == 3);
    vreq  = s.en && !full && !stype;
    ret   = vreq && s.rv && (n == 0);
    pop   = s.rv && (n > 0);
    for (int i = (pop ? 1 : 0); i < n; i++) live.push_back(mq[i]);
    if (vreq && !ret) live.push_back(int'(s.waddr));
    e.rdep = 0;
    e.wdep = 0;
    for (int p = 0; p < NRD; p++)
      if (s.rrv[p]) foreach (live[k]) if (live[k] == int'(s.rr[p*ADDR_W +: ADDR_W])) e.rdep = 1;
    for (int p = 0; p < NWR; p++)
      if (s.wrv[p]) foreach (live[k]) if (live[k] == int'(s.wr[p*ADDR_W +: ADDR_W])) e.wdep = 1;
    e.rdep  = e.rdep & s.dec;
    e.wdep  = e.wdep & s.dec;
    e.waddr = pop ? mq[0] : (ret ? int'(s.waddr) : 0);
    e.mc    = (last_lat == 3);
    e.sc    = (n == 0);
    e.act   = (n != 0);
    e.cnt   = n;
    e.ptype = stype;
    e.pcont = vreq && !s.gnt;
    e.stall = full || stype || e.pcont;
    e.spur  = s.rv && (n == 0) && !vreq;
    e.req   = vreq;
    if (s.sb) begin
      mq.delete();
      last_lat = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (vreq && s.gnt && !ret) mq.push_back(int'(s.waddr));
      if (vreq) last_lat = int'(s.lat);
    end
  endtask

  task automatic apply(input stim_t s);
    enable = s.en; lat = s.lat; waddr_in = s.waddr; gnt = s.gnt; rvalid = s.rv;
    setback = s.sb; is_decoding = s.dec; rregs = s.rr; rregs_v = s.rrv;
    wregs = s.wr; wregs_v = s.wrv;
  endtask

  task automatic step(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply(s);
    model_step(s, e);
    exp_q.push_back(e);
  endtask

  // Monitor: outputs settle half a cycle before the next edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("waddr_o",       32'(waddr_out),   32'(e.waddr));
        chk("multicycle_o",  32'(multicycle),  32'(e.mc));
        chk("singlecycle_o", 32'(singlecycle), 32'(e.sc));
        chk("active_o",      32'(active),      32'(e.act));
        chk("count_o",       32'(count),       32'(e.cnt));
        chk("stall_o",       32'(stall),       32'(e.stall));
        chk("read_dep_o",    32'(read_dep),    32'(e.rdep));
        chk("write_dep_o",   32'(write_dep),   32'(e.wdep));
        chk("perf_type_o",   32'(perf_type),   32'(e.ptype));
        chk("perf_cont_o",   32'(perf_cont),   32'(e.pcont));
        chk("spurious_o",    32'(spurious),    32'(e.spur));
        chk("apu_req_o",     32'(req),         32'(e.req));
      end
    end
  end

  initial begin
    stim_t s;
    exp_t  e;
    apply(idle());
    repeat (3) @(posedge clk);

    // Reset state.
    step(idle());

    // Fill to DEPTH, overflow request stalls, drain in order.
    step(req_s(2, 5, 1));
    step(req_s(2, 6, 1));
    step(req_s(2, 7, 1));
    step(req_s(2, 8, 1));
    step(ret_s());
    step(ret_s());
    step(ret_s());

    // Same-cycle return into an empty queue, then a nacked request.
    s = req_s(1, 9, 1); s.rv = 1; step(s);
    step(req_s(2, 10, 0));

    // Read/write dependency on a queued entry, cleared by its own pop.
    step(req_s(2, 12, 1));
    s = idle(); s.dec = 1; s.rr[1*ADDR_W +: ADDR_W] = 6'd12; s.rrv = 3'b010;
    s.wr[0 +: ADDR_W] = 6'd12; s.wrv = 2'b01; step(s);
    s.rv = 1; step(s);

    // Latency-ordering stalls behind a multicycle op.
    step(req_s(3, 20, 1));
    step(req_s(2, 21, 1));
    step(req_s(1, 22, 1));
    step(req_s(0, 23, 1));
    step(ret_s());
    step(ret_s());

    // Synchronous setback of a full queue.
    step(req_s(0, 30, 1));
    step(req_s(0, 31, 1));
    step(req_s(0, 32, 1));
    s = idle(); s.sb = 1; step(s);
    s = idle(); s.dec = 1; s.rr[0 +: ADDR_W] = 6'd30; s.rrv = 3'b001; step(s);

    // Async reset mid-operation clears immediately.
    step(req_s(3, 40, 1));
    step(req_s(0, 41, 0));
    @(posedge clk);
    #1;
    apply(idle());
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_active", 32'(active), 32'd0);
    chk("async_rst_multicycle", 32'(multicycle), 32'd0);
    mq.delete();
    last_lat = 0;
    model_step(idle(), e);
    exp_q.push_back(e);

    // Spurious response on an empty queue.
    step(ret_s());
    step(idle());

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      s = idle();
      s.en    = ($urandom_range(0, 99) < 60);
      s.lat   = 2'($urandom_range(0, 3));
      s.waddr = ADDR_W'($urandom_range(0, 7));
      s.gnt   = ($urandom_range(0, 99) < 75);
      s.rv    = ($urandom_range(0, 99) < 40);
      s.sb    = ($urandom_range(0, 99) < 2);
      s.dec   = $urandom_range(0, 1) != 0;
      for (int p = 0; p < NRD; p++) s.rr[p*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 7));
      for (int p = 0; p < NWR; p++) s.wr[p*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 7));
      s.rrv = NRD'($urandom);
      s.wrv = NWR'($urandom);
      step(s);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
